// File: rtl/regfile_port_arbiter_if.sv
// Bundle of request, response and register-file signals for regfile_port_arbiter.
// Ports (slave view, i.e. the arbiter):
//   req0_* / req1_*   : requests (valid, wr, a1, a2, wdata in; ready out)
//   resp0_* / resp1_* : responses (valid out, ready in)
//   resp_rd1/2, resp_dropped : shared response payload
//   rf_addr1/2, rf_addw, rf_wd, rf_we : register-file control (out)
//   rf_rd1/2          : register-file read data (in, combinational)
//   r0_drop_cnt       : saturating count of suppressed R0 writes
// The master modport is the environment side (requesters plus register file).
interface regfile_port_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 8
);
  logic              req0_valid, req0_ready, req0_wr;
  logic [ADDR_W-1:0] req0_a1, req0_a2;
  logic [DATA_W-1:0] req0_wdata;
  logic              req1_valid, req1_ready, req1_wr;
  logic [ADDR_W-1:0] req1_a1, req1_a2;
  logic [DATA_W-1:0] req1_wdata;
  logic              resp0_valid, resp0_ready;
  logic              resp1_valid, resp1_ready;
  logic [DATA_W-1:0] resp_rd1, resp_rd2;
  logic              resp_dropped;
  logic [ADDR_W-1:0] rf_addr1, rf_addr2, rf_addw;
  logic [DATA_W-1:0] rf_wd;
  logic              rf_we;
  logic [DATA_W-1:0] rf_rd1, rf_rd2;
  logic [CNT_W-1:0]  r0_drop_cnt;

  modport slave (
    input  req0_valid, req0_wr, req0_a1, req0_a2, req0_wdata,
    input  req1_valid, req1_wr, req1_a1, req1_a2, req1_wdata,
    input  resp0_ready, resp1_ready, rf_rd1, rf_rd2,
    output req0_ready, req1_ready, resp0_valid, resp1_valid,
    output resp_rd1, resp_rd2, resp_dropped,
    output rf_addr1, rf_addr2, rf_addw, rf_wd, rf_we, r0_drop_cnt
  );

  modport master (
    output req0_valid, req0_wr, req0_a1, req0_a2, req0_wdata,
    output req1_valid, req1_wr, req1_a1, req1_a2, req1_wdata,
    output resp0_ready, resp1_ready, rf_rd1, rf_rd2,
    input  req0_ready, req1_ready, resp0_valid, resp1_valid,
    input  resp_rd1, resp_rd2, resp_dropped,
    input  rf_addr1, rf_addr2, rf_addw, rf_wd, rf_we, r0_drop_cnt
  );
endinterface

// File: rtl/regfile_port_arbiter.sv
// Arbitrates an 8x16 register file (two combinational read ports, one clocked
// write port) between requester 0 (core control) and requester 1 (debug/load).
// Each accepted transaction (two-operand read or single write) runs through
// IDLE -> ISSUE -> RESP and returns its result with a valid/ready handshake.
// Writes to R0 are suppressed, flagged in the response and counted.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : regfile_port_arbiter_if.slave (requests, responses, register file)
module regfile_port_arbiter #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 3,
  parameter int FIXED_PRIO = 0,
  parameter int CNT_W      = 8
) (
  input logic                   clk,
  input logic                   rst,
  regfile_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t            state, state_nxt;
  logic              last_grant;
  logic              owner;
  logic              cur_wr;
  logic [ADDR_W-1:0] cur_a1, cur_a2;
  logic [DATA_W-1:0] cur_wd;
  logic [DATA_W-1:0] rd1_q, rd2_q;
  logic              dropped_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              sel1;
  logic              accept;

  // Requester 1 wins when it is alone, or in round-robin mode when requester
  // 0 was served last.
  assign sel1 = bus.req1_valid &&
                (!bus.req0_valid || ((FIXED_PRIO == 0) && !last_grant));

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_nxt      = state;
    accept         = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (!rst && (bus.req0_valid || bus.req1_valid)) begin
          bus.req0_ready = !sel1;
          bus.req1_ready = sel1;
          accept         = 1'b1;
          state_nxt      = ISSUE;
        end
      end
      ISSUE:   state_nxt = RESP;
      RESP:    if (owner ? bus.resp1_ready : bus.resp0_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.resp0_valid  = (state == RESP) && !owner;
  assign bus.resp1_valid  = (state == RESP) && owner;
  assign bus.resp_rd1     = rd1_q;
  assign bus.resp_rd2     = rd2_q;
  assign bus.resp_dropped = dropped_q;
  assign bus.r0_drop_cnt  = cnt_q;

  // Latched request fields drive the register file directly; outside ISSUE
  // they simply hold and only the write enable matters.
  assign bus.rf_addr1 = cur_a1;
  assign bus.rf_addr2 = cur_a2;
  assign bus.rf_addw  = cur_a1;
  assign bus.rf_wd    = cur_wd;
  // Reset gates the enable combinationally so a reset in ISSUE aborts the write.
  assign bus.rf_we    = (state == ISSUE) && cur_wr && (cur_a1 != '0) && !rst;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      cur_wr     <= 1'b0;
      cur_a1     <= '0;
      cur_a2     <= '0;
      cur_wd     <= '0;
      rd1_q      <= '0;
      rd2_q      <= '0;
      dropped_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner      <= sel1;
        last_grant <= sel1;
        cur_wr     <= sel1 ? bus.req1_wr    : bus.req0_wr;
        cur_a1     <= sel1 ? bus.req1_a1    : bus.req0_a1;
        cur_a2     <= sel1 ? bus.req1_a2    : bus.req0_a2;
        cur_wd     <= sel1 ? bus.req1_wdata : bus.req0_wdata;
      end
      if (state == ISSUE) begin
        if (cur_wr) begin
          rd1_q     <= '0;
          rd2_q     <= '0;
          dropped_q <= (cur_a1 == '0);
          if ((cur_a1 == '0) && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
        end else begin
          rd1_q     <= bus.rf_rd1;
          rd2_q     <= bus.rf_rd2;
          dropped_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/regfile_port_arbiter.md
Name: regfile_port_arbiter

Overview:
- Shares the 8x16 register file's ports (two combinational read ports, one clocked write port) between two requesters.
- Requester 0 is the core control path. Requester 1 is the debug/load port.
- Each accepted transaction is a two-operand read or a single write. It is sequenced through a 3-state FSM, and its response is returned with a valid/ready handshake.
- Writes to R0 are suppressed and counted.

Parameters:
- DATA_W, 16, register data width
- ADDR_W, 3, register address width
- FIXED_PRIO, 0, 0 = round-robin between requesters; 1 = requester 0 always wins
- CNT_W, 8, width of the R0-write-drop counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&&ready
- req0_wr / req1_wr  in  1  1 = write, 0 = read
- req0_a1 / req1_a1  in  ADDR_W  read address 1, or write address when wr=1
- req0_a2 / req1_a2  in  ADDR_W  read address 2 (ignored for writes)
- req0_wdata / req1_wdata  in  DATA_W  write data
- resp0_valid / resp1_valid  out  1  response valid
- resp0_ready / resp1_ready  in  1  response consumed when valid&&ready
- resp_rd1, resp_rd2  out  DATA_W  shared response data; read results, 0 for writes
- resp_dropped  out  1  response is for a write to R0 that was suppressed
- rf_addr1, rf_addr2, rf_addw  out  ADDR_W  register file addresses
- rf_wd  out  DATA_W  register file write data
- rf_we  out  1  register file write enable
- rf_rd1, rf_rd2  in  DATA_W  register file read data (combinational)
- r0_drop_cnt  out  CNT_W  saturating count of suppressed R0 writes

Behaviour:
- States: IDLE, ISSUE, RESP.
  - Reset: state=IDLE, last_grant=1 (requester 0 wins the first contest).
  - All outputs reset to 0: req*_ready, resp*_valid, resp_rd1/2, resp_dropped, r0_drop_cnt, rf_* = 0.
- IDLE:
  - reqN_ready=1 only for the selected requester, combinational from the valids.
  - Selection with one valid: that requester.
  - Selection with both valid: FIXED_PRIO=1 picks 0. FIXED_PRIO=0 picks the requester not equal to last_grant.
  - On handshake: latch wr/a1/a2/wdata and the owner, update last_grant, go to ISSUE.
  - No valid: stay in IDLE, both ready=0.
- ISSUE (exactly 1 cycle):
  - Drive rf_addr1=a1, rf_addr2=a2, rf_addw=a1, rf_wd=wdata.
  - rf_we = wr && (a1!=0) && !rst.
  - Read: capture rf_rd1/rf_rd2 into resp_rd1/2 at the closing edge.
  - Write: resp_rd1/2 = 0. resp_dropped = wr && (a1==0).
  - R0 write: r0_drop_cnt += 1, saturating at all-ones.
  - Go to RESP.
- Outside ISSUE: rf_we=0. rf_addr*/rf_wd hold their last values (don't-care).
- RESP:
  - respN_valid=1 for the owner only. Data and resp_dropped held stable until respN_ready.
  - On handshake: go to IDLE. The next request can be accepted the cycle after.
- Timing:
  - Minimum occupancy is 3 cycles per transaction (accept, issue, respond) when resp_ready is held high.
  - Read latency: accept edge + 2 cycles to resp_valid.
- Ordering: a write commits at the end of its ISSUE cycle. Any transaction accepted later observes the written value. No bypass is needed because transactions never overlap.
- Requester not granted: its ready stays 0. The requester must hold valid and its fields stable (standard valid/ready). Any valid pending in IDLE is guaranteed a grant within 2 transactions in round-robin mode.
- Reset mid-operation:
  - rst in ISSUE forces rf_we=0 that cycle, so no write occurs.
  - rst in any state returns to IDLE next edge; the in-flight transaction is discarded with no response.
  - The counter clears.
- resp_valid never asserts for the non-owner. req*_ready is never asserted outside IDLE.

Test Plan:
- Reset then req0 write a1=3, wdata=16'hA5A5 -> rf_we=1 with rf_addw=3 in the ISSUE cycle; resp0_valid 2 cycles after accept, resp_dropped=0. A following req0 read a1=3, a2=0 -> resp_rd1=16'hA5A5, resp_rd2=0.
- req1 write a1=0, wdata=16'hFFFF -> rf_we stays 0; resp_dropped=1, r0_drop_cnt=1. Repeat 300 times -> counter saturates at 255.
- Both requesters hold valid continuously, FIXED_PRIO=0 -> grants alternate 0,1,0,1. With FIXED_PRIO=1 -> requester 1 is never granted while req0_valid=1.
- Hold resp0_ready=0 for 5 cycles after a read -> resp0_valid and data stay stable. req1_valid waiting during that time sees ready=0; it is granted the cycle after resp0 handshake + IDLE.
- Assert rst during ISSUE of a write to R5 -> rf_we=0 that cycle, R5 unchanged on a subsequent read, no response, FSM in IDLE.
- Back-to-back write R2=16'h1234 (req0) then read R2 (req1) -> read returns 16'h1234; throughput of exactly 3 cycles per transaction with resp_ready=1.
